imm_field_encoder: RTL and testbench
====================================

# imm_field_encoder

Pipelined immediate encoder: the inverse of the decode-stage immediate generator. It accepts a signed 32-bit immediate, an immediate type (R/I/S/B/U/J) and a base instruction word. It scatters the immediate bits into the RV32I field positions and emits the merged 32-bit instruction through a 2-entry output buffer with valid/ready handshakes. It sits in the debug/boot path, where it patches instructions before they are written into instruction memory.

## Interface
- ERR_CNT_W, 8, width of the saturating error counter.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted on a cycle where in_valid && in_ready.
- in_type  in  3  immediate type: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are invalid.
- in_imm  in  32  immediate value, two's complement.
- in_base  in  32  base instruction; supplies every bit not occupied by the immediate.
- out_valid  out  1  encoded result present.
- out_ready  in  1  consumer accepts the result when out_valid && out_ready.
- out_inst  out  32  encoded instruction.
- out_err  out  1  the result's request failed encoding checks.
- err_cnt  out  ERR_CNT_W  count of accepted requests flagged in error; saturates at all-ones.

## Operation
- Encoding is combinational from the in_* signals. The encoded word and error flag are written into the buffer on an accepted request.
- Bits not listed for a type are copied from in_base.
- R: no bits replaced. An immediate of 0 is legal.
- I: inst[31:20] = imm[11:0]. Legal range is -2048..2047.
- S: inst[31:25] = imm[11:5]; inst[11:7] = imm[4:0]. Legal range is -2048..2047.
- B: inst[31] = imm[12]; inst[7] = imm[11]; inst[30:25] = imm[10:5]; inst[11:8] = imm[4:1]. Legal range is -4096..4094, and imm[0] must be 0.
- U: inst[31:12] = imm[31:12]. imm[11:0] must be 0.
- J: inst[31] = imm[20]; inst[19:12] = imm[19:12]; inst[20] = imm[11]; inst[30:21] = imm[10:1]. Legal range is -1048576..1048574, and imm[0] must be 0.
- Error on a valid type:
  - out_err = 1.
  - Immediate-occupied bits are forced to 0; all other bits come from in_base.
- Error on an invalid type (6 or 7):
  - out_err = 1.
  - out_inst = in_base unchanged.
- Errored results are still emitted in order and are never dropped.
- err_cnt increments by 1 per accepted errored request and holds at 2^ERR_CNT_W-1.
- Buffer: 2-entry FIFO with a 2-bit count.
  - State EMPTY (count 0) -> ONE on push.
  - ONE -> EMPTY on pop only; stays ONE on simultaneous push+pop; -> FULL on push only.
  - FULL (count 2) -> ONE on pop.
- in_ready = (count != 2). It is registered-state based and does not depend on out_ready, so there is no combinational in→out path.
- out_valid = (count != 0). out_inst and out_err always reflect the head entry.

## Timing
- Latency: a request accepted at edge N is visible on out_* after edge N when the buffer was empty.
- Throughput: 1 request per cycle while out_ready = 1.
- While FULL, in_ready = 0 and in_* are ignored, even if out_ready = 1 in the same cycle; the pop frees a slot for the next cycle.
- out_inst and out_err stay stable while out_valid && !out_ready.
- Reset values:
  - count = 0, so out_valid = 0 and in_ready = 1.
  - out_inst = 0, out_err = 0, err_cnt = 0.
  - FIFO pointers = 0.
- Reset asserted mid-operation discards buffered entries immediately, without waiting for a clock edge.

## Configuration
- IMM_RANGE_CHECK_EN defined: range and alignment checks are applied as listed in Operation.
- IMM_RANGE_CHECK_EN undefined:
  - No range or alignment checks.
  - Out-of-range bits are silently truncated; imm[0] is dropped for B/J, imm[11:0] is dropped for U, and imm is ignored for R.
  - out_err and err_cnt react only to invalid types.

## Test plan
- I: type=1, imm=0xFFFFFFFF, base=0x00000013 -> out_inst=0xFFF00013, out_err=0, one cycle after accept.
- B, U and J, back-to-back with out_ready=1, in order:
  - B: imm=8, base=0x00000063 -> 0x00000463.
  - U: imm=0x12345000, base=0x00000037 -> 0x12345037.
  - J: imm=0x800, base=0x0000006F -> 0x0010006F.
  - Required: results appear on three consecutive cycles.
- Errors with IMM_RANGE_CHECK_EN defined:
  - B, imm=3, base=0x00000063 -> out_inst=0x00000063, out_err=1, err_cnt=1.
  - type=7, base=0xDEADBEEF -> out_inst=0xDEADBEEF, out_err=1, err_cnt=2.
- Backpressure: out_ready=0, offer 3 requests -> in_ready=0 after 2 accepts; raise out_ready -> all 3 are emitted in order and out_inst is stable while stalled.
- Saturation: with ERR_CNT_W=2, send 5 errored requests -> err_cnt=3.
- Reset: with count=2, pulse rst asynchronously -> out_valid=0, in_ready=1, err_cnt=0 before the next clock edge.

Source files
------------

// File: rtl/imm_field_encoder.sv
`default_nettype none
// ============================================================================
// Module  : imm_field_encoder
// Brief   : Scatters a 32-bit immediate into RV32I I/S/B/U/J field positions
//           of a base instruction and emits it through a 2-entry output FIFO.
//           Define IMM_RANGE_CHECK_EN to enable range/alignment checking.
// Revision: 1.0 - initial release
// ============================================================================
module imm_field_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_type,
  input  logic [31:0]          in_imm,
  input  logic [31:0]          in_base,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [2:0] c_type_r = 3'd0;
  localparam logic [2:0] c_type_i = 3'd1;
  localparam logic [2:0] c_type_s = 3'd2;
  localparam logic [2:0] c_type_b = 3'd3;
  localparam logic [2:0] c_type_u = 3'd4;
  localparam logic [2:0] c_type_j = 3'd5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [31:0]           r_inst_mem [2];
  logic                  r_err_mem  [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [ERR_CNT_W-1:0]  r_err_cnt;

  logic [31:0]           w_mask;
  logic [31:0]           w_field;
  logic [31:0]           w_inst;
  logic                  w_type_ok;
  logic                  w_range_ok;
  logic                  w_err;
  logic                  w_push;
  logic                  w_pop;

  // w_mask marks the bits the immediate occupies; w_field holds them scattered.
  always_comb begin
    w_mask    = '0;
    w_field   = '0;
    w_type_ok = 1'b1;
    case (in_type)
      c_type_r: ;
      c_type_i: begin
        w_mask  = 32'hFFF0_0000;
        w_field = {in_imm[11:0], 20'b0};
      end
      c_type_s: begin
        w_mask  = 32'hFE00_0F80;
        w_field = {in_imm[11:5], 13'b0, in_imm[4:0], 7'b0};
      end
      c_type_b: begin
        w_mask  = 32'hFE00_0F80;
        w_field = {in_imm[12], in_imm[10:5], 13'b0, in_imm[4:1], in_imm[11], 7'b0};
      end
      c_type_u: begin
        w_mask  = 32'hFFFF_F000;
        w_field = {in_imm[31:12], 12'b0};
      end
      c_type_j: begin
        w_mask  = 32'hFFFF_F000;
        w_field = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], 12'b0};
      end
      default: w_type_ok = 1'b0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Signed range checks: every bit above the field's sign bit must match it.
  always_comb begin
    w_range_ok = 1'b1;
    case (in_type)
      c_type_r: w_range_ok = (in_imm == 32'b0);
      c_type_i,
      c_type_s: w_range_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
      c_type_b: w_range_ok = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
      c_type_u: w_range_ok = (in_imm[11:0] == 12'b0);
      c_type_j: w_range_ok = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
      default:  w_range_ok = 1'b1;
    endcase
  end
`else
  assign w_range_ok = 1'b1;
`endif

  assign w_err  = !w_type_ok || !w_range_ok;
  assign w_inst = (in_base & ~w_mask) | (w_range_ok ? w_field : 32'b0);
  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_push) w_state_nxt = ONE;
      ONE: begin
        if (w_push && !w_pop)      w_state_nxt = FULL;
        else if (w_pop && !w_push) w_state_nxt = EMPTY;
      end
      FULL:    if (w_pop) w_state_nxt = ONE;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_inst_mem[i] <= 32'b0;
        r_err_mem[i]  <= 1'b0;
      end
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_push) begin
        r_inst_mem[r_wr_ptr] <= w_inst;
        r_err_mem[r_wr_ptr]  <= w_err;
        r_wr_ptr             <= ~r_wr_ptr;
        if (w_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
          r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign out_inst  = r_inst_mem[r_rd_ptr];
  assign out_err   = r_err_mem[r_rd_ptr];
  assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_field_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_imm_field_encoder
// Brief   : Directed, table-driven bench for imm_field_encoder (ERR_CNT_W=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_imm_field_encoder;

`ifdef IMM_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [1:0]  err_cnt;

  int n_vec  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [2:0]  typ;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  vec_t vecs [15];

  imm_field_encoder #(.ERR_CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_type   (in_type),
    .in_imm    (in_imm),
    .in_base   (in_base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] base);
    in_valid = 1'b1;
    in_type  = t;
    in_imm   = imm;
    in_base  = base;
  endtask

  function automatic int bump(input int c, input logic e);
    return (e && c != 3) ? c + 1 : c;
  endfunction

  initial begin
    vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0};
    vecs[1]  = '{3'd3, 32'h0000_0008, 32'h0000_0063, 32'h0000_0463, 1'b0};
    vecs[2]  = '{3'd4, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0};
    vecs[3]  = '{3'd5, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 1'b0};
    vecs[4]  = '{3'd2, 32'h0000_07FF, 32'h0000_2023, 32'h7E00_2FA3, 1'b0};
    vecs[5]  = '{3'd3, 32'h0000_0003, 32'h0000_0063, CHK ? 32'h0000_0063 : 32'h0000_0163, CHK};
    vecs[6]  = '{3'd7, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
    vecs[7]  = '{3'd1, 32'h0000_0800, 32'h0000_0013, CHK ? 32'h0000_0013 : 32'h8000_0013, CHK};
    vecs[8]  = '{3'd5, 32'h0010_0000, 32'h0000_006F, CHK ? 32'h0000_006F : 32'h8000_006F, CHK};
    vecs[9]  = '{3'd4, 32'h1234_5678, 32'h0000_0037, CHK ? 32'h0000_0037 : 32'h1234_5037, CHK};
    vecs[10] = '{3'd0, 32'h0000_0005, 32'h00B5_0533, 32'h00B5_0533, CHK};
    vecs[11] = '{3'd6, 32'h0000_0001, 32'h1234_5678, 32'h1234_5678, 1'b1};
    vecs[12] = '{3'd0, 32'h0000_0000, 32'h0000_0033, 32'h0000_0033, 1'b0};
    vecs[13] = '{3'd5, 32'hFFFF_FFFE, 32'h0000_006F, 32'hFFFF_F06F, 1'b0};
    vecs[14] = '{3'd3, 32'hFFFF_F000, 32'h0000_0063, 32'h8000_0063, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_type = '0; in_imm = '0; in_base = '0; out_ready = 1'b1;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_inst",  out_inst,       32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
    check("rst_err_cnt",   32'(err_cnt),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back table: each result is visible one edge after its accept.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].typ, vecs[i].imm, vecs[i].base);
      @(posedge clk); #1;
      exp_cnt = bump(exp_cnt, vecs[i].err);
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_inst", i),  out_inst,       vecs[i].inst);
      check($sformatf("vec%0d_err", i),   32'(out_err),   32'(vecs[i].err));
      check($sformatf("vec%0d_cnt", i),   32'(err_cnt),   32'(exp_cnt));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: two accepts fill the buffer, third waits.
    out_ready = 1'b0;
    drive(3'd1, 32'd1, 32'h13);
    @(posedge clk); #1;
    check("bp_a_inst",  out_inst,       32'h0010_0013);
    check("bp_a_ready", 32'(in_ready),  32'd1);
    drive(3'd1, 32'd2, 32'h13);
    @(posedge clk); #1;
    check("bp_full_ready", 32'(in_ready), 32'd0);
    drive(3'd1, 32'd3, 32'h13);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("bp_stall_inst",  out_inst,      32'h0010_0013);
      check("bp_stall_ready", 32'(in_ready), 32'd0);
      check("bp_stall_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_b_inst",  out_inst,      32'h0020_0013);
    check("bp_b_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_c_inst",  out_inst,       32'h0030_0013);
    check("bp_c_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    check("bp_empty_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset with the buffer full.
    out_ready = 1'b0;
    drive(3'd7, 32'd0, 32'hA5A5_A5A5);
    @(posedge clk); #1;
    exp_cnt = bump(exp_cnt, 1'b1);
    @(posedge clk); #1;
    exp_cnt = bump(exp_cnt, 1'b1);
    in_valid = 1'b0;
    check("pre_rst_ready", 32'(in_ready), 32'd0);
    check("pre_rst_cnt",   32'(err_cnt),  32'(exp_cnt));
    check("pre_rst_inst",  out_inst,      32'hA5A5_A5A5);
    #3 rst = 1'b1;
    #1;
    exp_cnt = 0;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    check("arst_err_cnt",   32'(err_cnt),   32'd0);
    check("arst_out_inst",  out_inst,       32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // Saturation of the 2-bit error counter.
    out_ready = 1'b1;
    drive(3'd6, 32'd0, 32'h0000_0013);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      exp_cnt = bump(exp_cnt, 1'b1);
      check($sformatf("sat%0d_cnt", k),  32'(err_cnt), 32'(exp_cnt));
      check($sformatf("sat%0d_err", k),  32'(out_err), 32'd1);
      check($sformatf("sat%0d_inst", k), out_inst,     32'h0000_0013);
    end
    in_valid = 1'b0;
    check("sat_final", 32'(err_cnt), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
